// File: rtl/lc2k_multicycle_ctrl_if.sv
// Control bundle between the LC2K multi-cycle controller (master) and its datapath (slave).
`timescale 1ns/1ps
interface lc2k_multicycle_ctrl_if #(parameter int COUNT_WIDTH = 32);
  logic                   run;
  logic [2:0]             opcode;
  logic                   CONTROL_BEQ;
  logic                   memReady;
  logic [1:0]             CONTROL_OPERATION;
  logic                   aluSrcA;
  logic [1:0]             aluSrcB;
  logic                   aluOutWrite;
  logic                   memReq;
  logic                   memWrite;
  logic                   memAddrSel;
  logic                   irWrite;
  logic                   mdrWrite;
  logic                   regWrite;
  logic                   regDstSel;
  logic [1:0]             regDataSel;
  logic                   pcWrite;
  logic [1:0]             pcSrc;
  logic                   instRetired;
  logic [COUNT_WIDTH-1:0] instCount;
  logic                   halted;
  logic [COUNT_WIDTH-1:0] cycleCount;

  modport master (
    input  run, opcode, CONTROL_BEQ, memReady,
    output CONTROL_OPERATION, aluSrcA, aluSrcB, aluOutWrite, memReq, memWrite,
           memAddrSel, irWrite, mdrWrite, regWrite, regDstSel, regDataSel,
           pcWrite, pcSrc, instRetired, instCount, halted, cycleCount
  );

  modport slave (
    output run, opcode, CONTROL_BEQ, memReady,
    input  CONTROL_OPERATION, aluSrcA, aluSrcB, aluOutWrite, memReq, memWrite,
           memAddrSel, irWrite, mdrWrite, regWrite, regDstSel, regDataSel,
           pcWrite, pcSrc, instRetired, instCount, halted, cycleCount
  );
endinterface

// File: rtl/lc2k_multicycle_ctrl.sv
// LC2K multi-cycle control FSM: FETCH -> DECODE -> EXEC/MEM -> WB, one instruction per walk.
// Optional CTRL_CYCLE_COUNT_EN builds a cycle counter for non-IDLE/non-HALT states.
`timescale 1ns/1ps
module lc2k_multicycle_ctrl #(
  parameter int COUNT_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  lc2k_multicycle_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, EX_ADD, EX_NOR, WB_ALU, MEM_ADDR,
    MEM_RD, WB_MEM, MEM_WR, BEQ, JALR, HALT
  } state_e;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000, OP_NOR  = 3'b001, OP_LW   = 3'b010, OP_SW   = 3'b011,
    OP_BEQ  = 3'b100, OP_JALR = 3'b101, OP_HALT = 3'b110, OP_NOOP = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00, ALU_NOR = 2'b01, ALU_EQ = 2'b10
  } alu_e;

  typedef struct packed {
    logic [1:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       alu_out_write;
    logic       mem_req;
    logic       mem_write;
    logic       mem_addr_sel;
    logic       reg_write;
    logic       reg_dst_sel;
    logic [1:0] reg_data_sel;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       halted;
  } ctl_t;

  state_e                 state, state_d, boundary;
  ctl_t                   ctl_q;
  op_e                    op;
  logic                   retire;
  logic [COUNT_WIDTH-1:0] inst_count;

  assign op = op_e'(bus.opcode);

  function automatic ctl_t decode(state_e s);
    ctl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.mem_req   = 1'b1;
        c.alu_src_b = 2'd1;
        c.alu_op    = ALU_ADD;
      end
      DECODE: begin
        c.alu_src_b     = 2'd2;
        c.alu_op        = ALU_ADD;
        c.alu_out_write = 1'b1;
      end
      EX_ADD, EX_NOR: begin
        c.alu_src_a     = 1'b1;
        c.alu_op        = (s == EX_NOR) ? ALU_NOR : ALU_ADD;
        c.alu_out_write = 1'b1;
      end
      WB_ALU: c.reg_write = 1'b1;
      MEM_ADDR: begin
        c.alu_src_a     = 1'b1;
        c.alu_src_b     = 2'd2;
        c.alu_out_write = 1'b1;
      end
      MEM_RD: begin
        c.mem_req      = 1'b1;
        c.mem_addr_sel = 1'b1;
      end
      WB_MEM: begin
        c.reg_write    = 1'b1;
        c.reg_dst_sel  = 1'b1;
        c.reg_data_sel = 2'd1;
      end
      MEM_WR: begin
        c.mem_req      = 1'b1;
        c.mem_write    = 1'b1;
        c.mem_addr_sel = 1'b1;
      end
      BEQ: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = ALU_EQ;
        c.pc_src    = 2'd1;
      end
      // PC comes from the regA latch captured before this cycle's register write.
      JALR: begin
        c.reg_write    = 1'b1;
        c.reg_dst_sel  = 1'b1;
        c.reg_data_sel = 2'd2;
        c.pc_write     = 1'b1;
        c.pc_src       = 2'd2;
      end
      HALT:    c.halted = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    boundary = bus.run ? FETCH : IDLE;
    state_d  = state;
    retire   = 1'b0;
    case (state)
      IDLE:  if (bus.run) state_d = FETCH;
      FETCH: if (bus.memReady) state_d = DECODE;
      DECODE: begin
        case (op)
          OP_ADD:       state_d = EX_ADD;
          OP_NOR:       state_d = EX_NOR;
          OP_LW, OP_SW: state_d = MEM_ADDR;
          OP_BEQ:       state_d = BEQ;
          OP_JALR:      state_d = JALR;
          OP_HALT: begin
            state_d = HALT;
            retire  = 1'b1;
          end
          OP_NOOP: begin
            state_d = boundary;
            retire  = 1'b1;
          end
          default:      state_d = IDLE;
        endcase
      end
      EX_ADD, EX_NOR: state_d = WB_ALU;
      WB_ALU, WB_MEM, BEQ, JALR: begin
        state_d = boundary;
        retire  = 1'b1;
      end
      MEM_ADDR: state_d = (op == OP_LW) ? MEM_RD : MEM_WR;
      MEM_RD:   if (bus.memReady) state_d = WB_MEM;
      MEM_WR: begin
        if (bus.memReady) begin
          state_d = boundary;
          retire  = 1'b1;
        end
      end
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  // Moore outputs are registered off the next state so they line up with the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ctl_q      <= '0;
      inst_count <= '0;
    end else begin
      state <= state_d;
      ctl_q <= decode(state_d);
      if (retire) inst_count <= inst_count + COUNT_WIDTH'(1);
    end
  end

  assign bus.CONTROL_OPERATION = ctl_q.alu_op;
  assign bus.aluSrcA           = ctl_q.alu_src_a;
  assign bus.aluSrcB           = ctl_q.alu_src_b;
  assign bus.aluOutWrite       = ctl_q.alu_out_write;
  assign bus.memReq            = ctl_q.mem_req;
  assign bus.memWrite          = ctl_q.mem_write;
  assign bus.memAddrSel        = ctl_q.mem_addr_sel;
  assign bus.regWrite          = ctl_q.reg_write;
  assign bus.regDstSel         = ctl_q.reg_dst_sel;
  assign bus.regDataSel        = ctl_q.reg_data_sel;
  assign bus.pcSrc             = ctl_q.pc_src;
  assign bus.halted            = ctl_q.halted;
  assign bus.irWrite           = (state == FETCH) && bus.memReady;
  assign bus.mdrWrite          = (state == MEM_RD) && bus.memReady;
  assign bus.pcWrite           = ctl_q.pc_write
                               | ((state == FETCH) && bus.memReady)
                               | ((state == BEQ) && bus.CONTROL_BEQ);
  assign bus.instRetired       = retire;
  assign bus.instCount         = inst_count;

`ifdef CTRL_CYCLE_COUNT_EN
  logic [COUNT_WIDTH-1:0] cycle_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_count <= '0;
    end else if (state != IDLE && state != HALT) begin
      cycle_count <= cycle_count + COUNT_WIDTH'(1);
    end
  end

  assign bus.cycleCount = cycle_count;
`else
  assign bus.cycleCount = '0;
`endif

endmodule

// File: tb/tb_lc2k_multicycle_ctrl.sv
// Directed bench for lc2k_multicycle_ctrl: per-scenario tasks with inline hand-computed checks.
`timescale 1ns/1ps
module tb_lc2k_multicycle_ctrl;
  localparam int CW = 32;
  localparam logic [2:0] ADD = 3'b000, NOR = 3'b001, LW = 3'b010, SW = 3'b011;
  localparam logic [2:0] BEQ = 3'b100, JALR = 3'b101, HALT = 3'b110, NOOP = 3'b111;
`ifdef CTRL_CYCLE_COUNT_EN
  localparam logic [CW-1:0] EXP_CYC = 4;
`else
  localparam logic [CW-1:0] EXP_CYC = 0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   passed = 0;
  int   total  = 0;

  lc2k_multicycle_ctrl_if #(.COUNT_WIDTH(CW)) bus ();
  lc2k_multicycle_ctrl #(.COUNT_WIDTH(CW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  logic [20:0] ctl_all;
  assign ctl_all = {bus.CONTROL_OPERATION, bus.aluSrcA, bus.aluSrcB, bus.aluOutWrite,
                    bus.memReq, bus.memWrite, bus.memAddrSel, bus.irWrite, bus.mdrWrite,
                    bus.regWrite, bus.regDstSel, bus.regDataSel, bus.pcWrite, bus.pcSrc,
                    bus.instRetired, bus.halted};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    bus.run = 1'b0;
    bus.memReady = 1'b1;
    bus.CONTROL_BEQ = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    tick();
    #1;
    total++; if (ctl_all !== '0) $display("FAIL reset_outputs got %h want 0", ctl_all); else passed++;
    total++; if (bus.instCount !== '0) $display("FAIL reset_instcount got %0d want 0", bus.instCount); else passed++;
    total++; if (bus.cycleCount !== '0) $display("FAIL reset_cyclecount got %0d want 0", bus.cycleCount); else passed++;
    rst_n = 1'b1;
    tick();
    tick();
    total++; if (bus.memReq !== 1'b0) $display("FAIL idle_no_run_memreq got %b want 0", bus.memReq); else passed++;
  endtask

  task automatic test_add();
    apply_reset();
    bus.opcode = ADD;
    bus.run = 1'b1;
    tick(); #1;
    total++; if ({bus.memReq, bus.irWrite, bus.pcWrite, bus.aluSrcB, bus.pcSrc, bus.memAddrSel, bus.CONTROL_OPERATION, bus.regWrite} !== {1'b1, 1'b1, 1'b1, 2'd1, 2'd0, 1'b0, 2'b00, 1'b0})
      $display("FAIL add_fetch got %b%b%b %0d %0d %b %b rw=%b want 111 1 0 0 00 rw=0", bus.memReq, bus.irWrite, bus.pcWrite, bus.aluSrcB, bus.pcSrc, bus.memAddrSel, bus.CONTROL_OPERATION, bus.regWrite); else passed++;
    tick(); #1;
    total++; if ({bus.aluSrcA, bus.aluSrcB, bus.aluOutWrite, bus.CONTROL_OPERATION, bus.regWrite, bus.memReq} !== {1'b0, 2'd2, 1'b1, 2'b00, 1'b0, 1'b0})
      $display("FAIL add_decode got %b %0d %b %b %b %b want 0 2 1 00 0 0", bus.aluSrcA, bus.aluSrcB, bus.aluOutWrite, bus.CONTROL_OPERATION, bus.regWrite, bus.memReq); else passed++;
    tick(); #1;
    total++; if ({bus.aluSrcA, bus.aluSrcB, bus.aluOutWrite, bus.CONTROL_OPERATION, bus.regWrite} !== {1'b1, 2'd0, 1'b1, 2'b00, 1'b0})
      $display("FAIL add_exec got %b %0d %b %b %b want 1 0 1 00 0", bus.aluSrcA, bus.aluSrcB, bus.aluOutWrite, bus.CONTROL_OPERATION, bus.regWrite); else passed++;
    tick(); bus.run = 1'b0; #1;
    total++; if ({bus.regWrite, bus.regDstSel, bus.regDataSel, bus.instRetired, bus.aluOutWrite} !== {1'b1, 1'b0, 2'd0, 1'b1, 1'b0})
      $display("FAIL add_wb got %b %b %0d %b %b want 1 0 0 1 0", bus.regWrite, bus.regDstSel, bus.regDataSel, bus.instRetired, bus.aluOutWrite); else passed++;
    tick(); #1;
    total++; if ({bus.regWrite, bus.instRetired, bus.memReq} !== 3'b000) $display("FAIL add_idle got %b%b%b want 000", bus.regWrite, bus.instRetired, bus.memReq); else passed++;
    total++; if (bus.instCount !== 32'd1) $display("FAIL add_instcount got %0d want 1", bus.instCount); else passed++;
  endtask

  task automatic test_lw_wait();
    int mreq = 0, mdr_cnt = 0, mdr_at = 0, ret_at = 0;
    apply_reset();
    bus.opcode = LW;
    bus.run = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      bus.memReady = !(c == 4 || c == 5);
      if (c == 7) bus.run = 1'b0;
      #1;
      if (bus.memReq) mreq++;
      if (bus.mdrWrite) begin mdr_cnt++; mdr_at = c; end
      if (bus.instRetired) ret_at = c;
      if (c == 3) begin
        total++; if ({bus.aluSrcA, bus.aluSrcB, bus.aluOutWrite} !== {1'b1, 2'd2, 1'b1})
          $display("FAIL lw_memaddr got %b %0d %b want 1 2 1", bus.aluSrcA, bus.aluSrcB, bus.aluOutWrite); else passed++;
      end
      if (c == 4) begin
        total++; if ({bus.memReq, bus.memAddrSel, bus.mdrWrite, bus.memWrite} !== 4'b1100)
          $display("FAIL lw_memrd_wait got %b%b%b%b want 1100", bus.memReq, bus.memAddrSel, bus.mdrWrite, bus.memWrite); else passed++;
      end
      if (c == 7) begin
        total++; if ({bus.regWrite, bus.regDstSel, bus.regDataSel} !== {1'b1, 1'b1, 2'd1})
          $display("FAIL lw_wbmem got %b %b %0d want 1 1 1", bus.regWrite, bus.regDstSel, bus.regDataSel); else passed++;
      end
    end
    total++; if (mreq !== 4) $display("FAIL lw_memreq_cycles got %0d want 4", mreq); else passed++;
    total++; if (mdr_cnt !== 1 || mdr_at !== 6) $display("FAIL lw_mdrwrite got cnt=%0d at=%0d want cnt=1 at=6", mdr_cnt, mdr_at); else passed++;
    total++; if (ret_at !== 7) $display("FAIL lw_latency got %0d want 7", ret_at); else passed++;
    total++; if (bus.instCount !== 32'd1) $display("FAIL lw_instcount got %0d want 1", bus.instCount); else passed++;
  endtask

  task automatic test_beq_twice();
    int pc1 = 0;
    apply_reset();
    bus.opcode = BEQ;
    bus.run = 1'b1;
    bus.CONTROL_BEQ = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      tick();
      bus.CONTROL_BEQ = (c <= 3);
      bus.run = (c < 6);
      #1;
      if (bus.pcWrite && bus.pcSrc == 2'd1) pc1++;
      if (c == 2) begin
        total++; if (bus.pcWrite !== 1'b0) $display("FAIL beq_decode_pcwrite got %b want 0", bus.pcWrite); else passed++;
      end
      if (c == 3) begin
        total++; if ({bus.pcWrite, bus.pcSrc, bus.CONTROL_OPERATION, bus.aluSrcA, bus.aluSrcB, bus.instRetired} !== {1'b1, 2'd1, 2'b10, 1'b1, 2'd0, 1'b1})
          $display("FAIL beq_taken got %b %0d %b %b %0d %b want 1 1 10 1 0 1", bus.pcWrite, bus.pcSrc, bus.CONTROL_OPERATION, bus.aluSrcA, bus.aluSrcB, bus.instRetired); else passed++;
      end
      if (c == 6) begin
        total++; if ({bus.pcWrite, bus.instRetired, bus.CONTROL_OPERATION} !== {1'b0, 1'b1, 2'b10})
          $display("FAIL beq_not_taken got %b %b %b want 0 1 10", bus.pcWrite, bus.instRetired, bus.CONTROL_OPERATION); else passed++;
      end
    end
    total++; if (pc1 !== 1) $display("FAIL beq_pcsrc1_writes got %0d want 1", pc1); else passed++;
    total++; if (bus.instCount !== 32'd2) $display("FAIL beq_instcount got %0d want 2", bus.instCount); else passed++;
  endtask

  task automatic test_halt();
    int ret_cnt = 0, mreq_after = 0, not_halted = 0;
    apply_reset();
    bus.opcode = NOOP;
    bus.run = 1'b1;
    for (int c = 1; c <= 25; c++) begin
      tick();
      if (c == 3) bus.opcode = HALT;
      #1;
      if (bus.instRetired) ret_cnt++;
      if (c == 4) begin
        total++; if ({bus.halted, bus.instRetired} !== 2'b01) $display("FAIL halt_decode got h=%b r=%b want h=0 r=1", bus.halted, bus.instRetired); else passed++;
      end
      if (c >= 5) begin
        if (bus.memReq) mreq_after++;
        if (!bus.halted) not_halted++;
      end
    end
    total++; if (not_halted !== 0) $display("FAIL halt_sticky got %0d low cycles want 0", not_halted); else passed++;
    total++; if (mreq_after !== 0) $display("FAIL halt_memreq got %0d cycles want 0", mreq_after); else passed++;
    total++; if (ret_cnt !== 2 || bus.instCount !== 32'd2) $display("FAIL halt_retire got pulses=%0d count=%0d want 2 2", ret_cnt, bus.instCount); else passed++;
  endtask

  task automatic test_reset_mid_memwr();
    apply_reset();
    bus.opcode = NOOP;
    bus.run = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (c == 3) bus.opcode = SW;
      if (c == 5) bus.memReady = 1'b0;
      #1;
    end
    total++; if ({bus.memReq, bus.memWrite, bus.memAddrSel, bus.instRetired} !== 4'b1110)
      $display("FAIL sw_memwr got %b%b%b%b want 1110", bus.memReq, bus.memWrite, bus.memAddrSel, bus.instRetired); else passed++;
    total++; if (bus.instCount !== 32'd1) $display("FAIL sw_pre_reset_count got %0d want 1", bus.instCount); else passed++;
    #1 rst_n = 1'b0;
    #1;
    total++; if (ctl_all !== '0) $display("FAIL async_reset_outputs got %h want 0", ctl_all); else passed++;
    total++; if (bus.instCount !== '0 || bus.cycleCount !== '0) $display("FAIL async_reset_counters got %0d %0d want 0 0", bus.instCount, bus.cycleCount); else passed++;
    tick();
    bus.memReady = 1'b1;
    rst_n = 1'b1;
    #1;
    total++; if (bus.memReq !== 1'b0) $display("FAIL post_reset_idle got %b want 0", bus.memReq); else passed++;
    tick(); #1;
    total++; if ({bus.memReq, bus.irWrite} !== 2'b11) $display("FAIL post_reset_fetch got %b%b want 11", bus.memReq, bus.irWrite); else passed++;
  endtask

  task automatic test_run_drop_nor();
    apply_reset();
    bus.opcode = NOR;
    bus.run = 1'b1;
    tick(); #1;
    tick(); #1;
    tick(); bus.run = 1'b0; #1;
    total++; if ({bus.CONTROL_OPERATION, bus.aluSrcA, bus.aluSrcB, bus.aluOutWrite} !== {2'b01, 1'b1, 2'd0, 1'b1})
      $display("FAIL nor_exec got %b %b %0d %b want 01 1 0 1", bus.CONTROL_OPERATION, bus.aluSrcA, bus.aluSrcB, bus.aluOutWrite); else passed++;
    tick(); #1;
    total++; if ({bus.regWrite, bus.instRetired} !== 2'b11) $display("FAIL nor_wb got %b%b want 11", bus.regWrite, bus.instRetired); else passed++;
    tick(); #1;
    total++; if (bus.memReq !== 1'b0 || bus.instCount !== 32'd1) $display("FAIL nor_idle got req=%b count=%0d want 0 1", bus.memReq, bus.instCount); else passed++;
    total++; if (bus.cycleCount !== EXP_CYC) $display("FAIL nor_cyclecount got %0d want %0d", bus.cycleCount, EXP_CYC); else passed++;
    tick(); tick(); tick(); #1;
    total++; if (bus.cycleCount !== EXP_CYC || bus.memReq !== 1'b0) $display("FAIL nor_frozen got cyc=%0d req=%b want %0d 0", bus.cycleCount, bus.memReq, EXP_CYC); else passed++;
  endtask

  task automatic test_jalr();
    apply_reset();
    bus.opcode = JALR;
    bus.run = 1'b1;
    tick(); #1;
    tick(); #1;
    tick(); bus.run = 1'b0; #1;
    total++; if ({bus.regWrite, bus.regDstSel, bus.regDataSel, bus.pcWrite, bus.pcSrc, bus.instRetired} !== {1'b1, 1'b1, 2'd2, 1'b1, 2'd2, 1'b1})
      $display("FAIL jalr got %b %b %0d %b %0d %b want 1 1 2 1 2 1", bus.regWrite, bus.regDstSel, bus.regDataSel, bus.pcWrite, bus.pcSrc, bus.instRetired); else passed++;
    tick(); #1;
    total++; if (bus.instCount !== 32'd1 || bus.pcWrite !== 1'b0) $display("FAIL jalr_after got count=%0d pcw=%b want 1 0", bus.instCount, bus.pcWrite); else passed++;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.run = 1'b0;
    bus.opcode = NOOP;
    bus.CONTROL_BEQ = 1'b0;
    bus.memReady = 1'b1;
    test_reset();
    test_add();
    test_lw_wait();
    test_beq_twice();
    test_halt();
    test_reset_mid_memwr();
    test_run_drop_nor();
    test_jalr();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
